// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and constants for the MM:SS stopwatch counter
package counter_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t TENS_MAX = 4'd5;
    localparam bcd_t ONES_MAX = 4'd9;

    localparam logic SEL_MIN = 1'b0;
    localparam logic SEL_SEC = 1'b1;

endpackage

// File: rtl/counter_mod60_bcd.sv
// rtl/counter_mod60_bcd.sv - two-digit BCD modulo-60 counter with registered digits
module mod60_bcd
    import counter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output bcd_t tens,
    output bcd_t ones,
    output logic carry_out
);

    bcd_t r_tens;
    bcd_t r_ones;
    logic w_at_max;

    assign w_at_max  = (r_tens == TENS_MAX) && (r_ones == ONES_MAX);
    assign carry_out = inc & w_at_max;
    assign tens      = r_tens;
    assign ones      = r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else if (inc) begin
            if (r_ones == ONES_MAX) begin
                r_ones <= '0;
                r_tens <= (r_tens == TENS_MAX) ? bcd_t'(0) : bcd_t'(r_tens + 4'd1);
            end else begin
                r_ones <= bcd_t'(r_ones + 4'd1);
            end
        end
    end

endmodule

// File: rtl/counter.sv
// rtl/counter.sv - MM:SS stopwatch time-base: 1 Hz counting, 2 Hz field adjust
module counter
    import counter_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               pause,
    input  logic               adj,
    input  logic               sel,
    output logic [DIGIT_W-1:0] minutes_top_digit,
    output logic [DIGIT_W-1:0] minutes_bot_digit,
    output logic [DIGIT_W-1:0] seconds_top_digit,
    output logic [DIGIT_W-1:0] seconds_bot_digit,
    output logic               is_minute_increasing,
    output logic               is_second_increasing
);

    logic w_normal_step;
    logic w_adj_step;
    logic w_sec_inc;
    logic w_min_inc;
    logic w_sec_carry;
    logic w_min_carry;
    bcd_t w_sec_tens, w_sec_ones;
    bcd_t w_min_tens, w_min_ones;

    // Only the strobe belonging to the current mode can step; pause gates normal mode only.
    assign w_normal_step = ~adj & ~pause & tick_1hz;
    assign w_adj_step    = adj & tick_2hz;

    assign w_sec_inc = w_normal_step | (w_adj_step & (sel == SEL_SEC));
    assign w_min_inc = (~adj & w_sec_carry) | (w_adj_step & (sel == SEL_MIN));

    mod60_bcd u_seconds (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_sec_inc),
        .tens      (w_sec_tens),
        .ones      (w_sec_ones),
        .carry_out (w_sec_carry)
    );

    mod60_bcd u_minutes (
        .clk       (clk),
        .rst       (rst),
        .inc       (w_min_inc),
        .tens      (w_min_tens),
        .ones      (w_min_ones),
        .carry_out (w_min_carry)
    );

    assign minutes_top_digit = DIGIT_W'(w_min_tens);
    assign minutes_bot_digit = DIGIT_W'(w_min_ones);
    assign seconds_top_digit = DIGIT_W'(w_sec_tens);
    assign seconds_bot_digit = DIGIT_W'(w_sec_ones);

    assign is_minute_increasing = adj & (sel == SEL_MIN);
    assign is_second_increasing = adj & (sel == SEL_SEC);

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - scoreboard testbench for the MM:SS stopwatch counter
module tb_counter;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       tick_2hz;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] minutes_top_digit;
    logic [3:0] minutes_bot_digit;
    logic [3:0] seconds_top_digit;
    logic [3:0] seconds_bot_digit;
    logic       is_minute_increasing;
    logic       is_second_increasing;

    int n_tests = 0;
    int n_fail  = 0;

    string       name_q[$];
    logic [15:0] dig_q[$];
    logic [1:0]  flag_q[$];

    counter #(.DIGIT_W(4)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .tick_1hz             (tick_1hz),
        .tick_2hz             (tick_2hz),
        .pause                (pause),
        .adj                  (adj),
        .sel                  (sel),
        .minutes_top_digit    (minutes_top_digit),
        .minutes_bot_digit    (minutes_bot_digit),
        .seconds_top_digit    (seconds_top_digit),
        .seconds_bot_digit    (seconds_bot_digit),
        .is_minute_increasing (is_minute_increasing),
        .is_second_increasing (is_second_increasing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compares the display outputs against every queued expectation.
    always @(negedge clk) begin
        while (name_q.size() > 0) begin
            string       nm;
            logic [15:0] ed;
            logic [1:0]  ef;
            logic [15:0] ad;
            nm = name_q.pop_front();
            ed = dig_q.pop_front();
            ef = flag_q.pop_front();
            ad = {minutes_top_digit, minutes_bot_digit, seconds_top_digit, seconds_bot_digit};
            n_tests++;
            if (ad !== ed || {is_minute_increasing, is_second_increasing} !== ef) begin
                n_fail++;
                $display("FAIL %s: got %h mi=%b si=%b, expected %h mi=%b si=%b",
                         nm, ad, is_minute_increasing, is_second_increasing, ed, ef[1], ef[0]);
            end
        end
    end

    task automatic expect_state(input string nm, input logic [15:0] d, input logic mi, input logic si);
        name_q.push_back(nm);
        dig_q.push_back(d);
        flag_q.push_back({mi, si});
        @(posedge clk);
        #1;
    endtask

    task automatic tick1(input int n);
        tick_1hz = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick_1hz = 1'b0;
    endtask

    task automatic tick2(input int n);
        tick_2hz = 1'b1;
        repeat (n) @(posedge clk);
        #1 tick_2hz = 1'b0;
    endtask

    task automatic both_ticks();
        tick_1hz = 1'b1;
        tick_2hz = 1'b1;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        tick_2hz = 1'b0;
    endtask

    initial begin
        rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0;
        pause = 1'b0; adj = 1'b0; sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_state("reset_state", 16'h0000, 1'b0, 1'b0);

        tick1(3);
        expect_state("pre_reset_count", 16'h0003, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        expect_state("reset_clears", 16'h0000, 1'b0, 1'b0);

        rst = 1'b1;
        tick1(3);
        expect_state("reset_over_tick", 16'h0000, 1'b0, 1'b0);
        rst = 1'b0;

        tick1(59);
        expect_state("count_00_59", 16'h0059, 1'b0, 1'b0);
        tick1(1);
        expect_state("carry_01_00", 16'h0100, 1'b0, 1'b0);
        tick1(539);
        expect_state("count_09_59", 16'h0959, 1'b0, 1'b0);
        tick1(1);
        expect_state("carry_10_00", 16'h1000, 1'b0, 1'b0);
        tick1(2999);
        expect_state("count_59_59", 16'h5959, 1'b0, 1'b0);
        tick1(1);
        expect_state("wrap_00_00", 16'h0000, 1'b0, 1'b0);

        tick2(4);
        expect_state("normal_ignores_2hz", 16'h0000, 1'b0, 1'b0);

        tick1(10);
        expect_state("count_00_10", 16'h0010, 1'b0, 1'b0);
        pause = 1'b1;
        tick1(5);
        expect_state("pause_holds_1hz", 16'h0010, 1'b0, 1'b0);
        tick2(3);
        expect_state("pause_holds_2hz", 16'h0010, 1'b0, 1'b0);
        pause = 1'b0;
        tick1(1);
        expect_state("pause_resume", 16'h0011, 1'b0, 1'b0);

        tick1(47);
        expect_state("count_00_58", 16'h0058, 1'b0, 1'b0);
        adj = 1'b1; sel = 1'b0;
        tick2(3);
        expect_state("adj_min_03_58", 16'h0358, 1'b1, 1'b0);
        tick1(4);
        expect_state("adj_ignores_1hz", 16'h0358, 1'b1, 1'b0);
        tick2(56);
        expect_state("adj_min_59_58", 16'h5958, 1'b1, 1'b0);
        tick2(1);
        expect_state("adj_min_wrap", 16'h0058, 1'b1, 1'b0);
        tick2(7);
        expect_state("adj_min_07_58", 16'h0758, 1'b1, 1'b0);

        sel = 1'b1;
        tick2(3);
        expect_state("adj_sec_wrap", 16'h0701, 1'b0, 1'b1);
        pause = 1'b1;
        tick2(1);
        expect_state("adj_ignores_pause", 16'h0702, 1'b0, 1'b1);
        pause = 1'b0;

        adj = 1'b0;
        both_ticks();
        expect_state("both_normal", 16'h0703, 1'b0, 1'b0);
        adj = 1'b1; sel = 1'b1;
        both_ticks();
        expect_state("both_adj_sec", 16'h0704, 1'b0, 1'b1);
        sel = 1'b0;
        both_ticks();
        expect_state("both_adj_min", 16'h0804, 1'b1, 1'b0);

        rst = 1'b1;
        tick2(1);
        rst = 1'b0;
        expect_state("reset_mid_adjust", 16'h0000, 1'b1, 1'b0);
        adj = 1'b0;
        expect_state("flags_normal", 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 10 && name_q.size() > 0; i++) @(posedge clk);
        if (name_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending checks, expected 0", name_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
